bcd_stopwatch: RTL and testbench

BCD_STOPWATCH -- requirements
Module: bcd_stopwatch

---
 rtl/bcd_stopwatch.sv | 92 +++++++++
 tb/tb_bcd_stopwatch.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/bcd_stopwatch.sv
// bcd_stopwatch: four-digit BCD stopwatch with prescaled tick, pause/resume,
// lap freeze of the display and a one-cycle rollover pulse.
module bcd_stopwatch #(
    parameter int TICK_DIV = 100000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_stop,
    input  logic        clear,
    input  logic        lap,
    output logic [15:0] digits,
    output logic        running,
    output logic        lap_active,
    output logic        wrap
);
    localparam int PW = $clog2(TICK_DIV);

    typedef enum logic {ST_STOPPED, ST_RUNNING} state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [PW-1:0]   r_presc;
    logic [15:0]     r_count;
    logic [15:0]     r_lap;
    logic            r_lap_active;
    logic            r_wrap;
    logic            w_run;
    logic            w_tick;
    logic            w_carry;
    logic [15:0]     w_count_inc;

    assign w_run  = (r_state == ST_RUNNING);
    assign w_tick = w_run && (r_presc == PW'(TICK_DIV - 1));

    always_ff @(posedge clk) begin
        if (!rst_n)
            r_state <= ST_STOPPED;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (clear)
            w_state_nxt = ST_STOPPED;
        else if (start_stop)
            w_state_nxt = w_run ? ST_STOPPED : ST_RUNNING;
    end

    // Ripple the tick through the digits; a 9 with carry-in becomes 0.
    always_comb begin
        w_carry     = w_tick;
        w_count_inc = r_count;
        for (int i = 0; i < 4; i++) begin
            if (w_carry)
                w_count_inc[i*4 +: 4] = (r_count[i*4 +: 4] == 4'd9) ? 4'd0 : r_count[i*4 +: 4] + 4'd1;
            w_carry = w_carry && (r_count[i*4 +: 4] == 4'd9);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_presc      <= '0;
            r_count      <= '0;
            r_lap        <= '0;
            r_lap_active <= 1'b0;
            r_wrap       <= 1'b0;
        end else if (clear) begin
            r_presc      <= '0;
            r_count      <= '0;
            r_lap_active <= 1'b0;
            r_wrap       <= 1'b0;
        end else begin
            r_wrap <= w_carry;
            if (w_run)
                r_presc <= w_tick ? '0 : r_presc + 1'b1;
            if (w_tick)
                r_count <= w_count_inc;
            // Lap snapshots the pre-increment count.
            if (lap) begin
                if (!r_lap_active)
                    r_lap <= r_count;
                r_lap_active <= !r_lap_active;
            end
        end
    end

    assign digits     = r_lap_active ? r_lap : r_count;
    assign running    = w_run;
    assign lap_active = r_lap_active;
    assign wrap       = r_wrap;
endmodule

// File: tb/tb_bcd_stopwatch.sv
// tb_bcd_stopwatch: directed scenarios plus random pulses checked every cycle
// against an integer-arithmetic model of the stopwatch.
module tb_bcd_stopwatch;
    localparam int TD = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_stop = 1'b0;
    logic        clear = 1'b0;
    logic        lap = 1'b0;
    logic [15:0] digits;
    logic        running;
    logic        lap_active;
    logic        wrap;

    int n_chk = 0;
    int n_fail = 0;

    int m_cnt = 0;
    int m_presc = 0;
    int m_lap = 0;
    bit m_run = 0;
    bit m_la = 0;
    bit m_wrap = 0;
    int wrap_seen;

    bcd_stopwatch #(.TICK_DIV(TD)) dut (
        .clk(clk), .rst_n(rst_n), .start_stop(start_stop), .clear(clear),
        .lap(lap), .digits(digits), .running(running),
        .lap_active(lap_active), .wrap(wrap)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int n);
        return {4'(n / 1000), 4'((n / 100) % 10), 4'((n / 10) % 10), 4'(n % 10)};
    endfunction

    task automatic model_edge(input bit ss, input bit clr, input bit lp);
        bit tick;
        if (!rst_n) begin
            m_cnt = 0; m_presc = 0; m_lap = 0; m_run = 0; m_la = 0; m_wrap = 0;
        end else if (clr) begin
            m_cnt = 0; m_presc = 0; m_run = 0; m_la = 0; m_wrap = 0;
        end else begin
            tick   = m_run && (m_presc == TD - 1);
            m_wrap = tick && (m_cnt == 9999);
            if (lp) begin
                if (!m_la) m_lap = m_cnt;
                m_la = !m_la;
            end
            if (m_run) m_presc = tick ? 0 : m_presc + 1;
            if (tick) m_cnt = (m_cnt + 1) % 10000;
            if (ss) m_run = !m_run;
        end
    endtask

    task automatic step(input bit ss, input bit clr, input bit lp);
        start_stop = ss; clear = clr; lap = lp;
        @(posedge clk);
        model_edge(ss, clr, lp);
        #1;
        chk("digits", 32'(digits), 32'(to_bcd(m_la ? m_lap : m_cnt)));
        chk("running", 32'(running), 32'(m_run));
        chk("lap_active", 32'(lap_active), 32'(m_la));
        chk("wrap", 32'(wrap), 32'(m_wrap));
        if (wrap) wrap_seen++;
        start_stop = 0; clear = 0; lap = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0);
    endtask

    initial begin
        rst_n = 0;
        idle(3);
        rst_n = 1;
        chk("reset_digits", 32'(digits), 32'h0);
        chk("reset_running", 32'(running), 32'h0);

        step(1, 0, 0);
        idle(3);
        chk("no_tick_yet", 32'(digits), 32'h0);
        step(0, 0, 0);
        chk("first_tick", 32'(digits), 32'h1);
        idle(36);
        chk("count_0010", 32'(digits), 32'h0010);

        step(0, 1, 0);
        step(1, 0, 0);
        idle(5);
        step(1, 0, 0);
        idle(20);
        chk("paused_0001", 32'(digits), 32'h0001);
        step(1, 0, 0);
        step(0, 0, 0);
        chk("resume_hold", 32'(digits), 32'h0001);
        step(0, 0, 0);
        chk("resume_tick", 32'(digits), 32'h0002);

        step(0, 1, 0);
        step(1, 0, 0);
        for (int i = 0; i < 100 && m_cnt != 5; i++) step(0, 0, 0);
        step(0, 0, 1);
        idle(20);
        chk("frozen_0005", 32'(digits), 32'h0005);
        step(0, 0, 1);
        chk("unfrozen_0010", 32'(digits), 32'h0010);
        chk("unfrozen_la", 32'(lap_active), 32'h0);
        step(0, 0, 1);
        step(1, 1, 1);
        chk("clr_digits", 32'(digits), 32'h0);
        chk("clr_running", 32'(running), 32'h0);
        chk("clr_la", 32'(lap_active), 32'h0);

        step(1, 0, 0);
        wrap_seen = 0;
        idle(TD * 10000);
        chk("roll_digits", 32'(digits), 32'h0);
        chk("roll_running", 32'(running), 32'h1);
        chk("roll_wrap_cnt", 32'(wrap_seen), 32'h1);
        idle(2);
        chk("wrap_low", 32'(wrap), 32'h0);

        rst_n = 0;
        step(0, 0, 1);
        rst_n = 1;
        chk("reset_mid", 32'(digits), 32'h0);

        for (int i = 0; i < 3000; i++) begin
            rst_n = ($urandom_range(0, 199) != 0);
            step($urandom_range(0, 15) == 0, $urandom_range(0, 63) == 0, $urandom_range(0, 15) == 0);
        end
        rst_n = 1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
